// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame assembler.
// Holds default frame geometry, the FSM state type and the timeout helper.
package uart_pkg;

    localparam int unsigned N_BYTES_DEFAULT = 3;
    localparam int unsigned BYTE_W_DEFAULT  = 8;

    typedef enum logic {
        IDLE,
        COLLECT
    } asm_state_t;

    // Whole-MHz clock assumed; the fractional part is dropped.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/uart_frame_assembler_gap_timer.sv
// Saturating inter-byte gap counter.
// The expired output is high while the count sits at TIMEOUT_CYCLES-1.
module gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_assembler.sv
// Packs N_BYTES received bytes into one word, first byte in the MSBs.
// Partial frames are dropped on a receiver error or an inter-byte gap timeout.
module uart_frame_assembler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27_000_000,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned N_BYTES     = N_BYTES_DEFAULT,
    parameter int unsigned BYTE_W      = BYTE_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BYTE_W-1:0]         uart_rx_data,
    input  logic                      rx_valid,
    input  logic                      rx_err,
    output logic [N_BYTES*BYTE_W-1:0] uart_rx_bytes,
    output logic                      bytes_valid,
    output logic                      frame_err,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int unsigned FRAME_W        = N_BYTES * BYTE_W;
    localparam int unsigned PART_W         = (N_BYTES - 1) * BYTE_W;
    localparam int unsigned CNT_W          = $clog2(N_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_BYTES - 1);

    asm_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PART_W-1:0]   shreg_q, shreg_d;
    logic [FRAME_W-1:0]  out_q, out_d;
    logic                bv_q, bv_d;
    logic                fe_q, fe_d;
    logic                te_q, te_d;
    logic                timer_clear;
    logic                timer_run;
    logic                timer_expired;
    logic [FRAME_W-1:0]  shifted;

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clear),
        .run_i    (timer_run),
        .expired_o(timer_expired)
    );

    // Full word with the new byte appended; the low part is the next partial.
    assign shifted = {shreg_q, uart_rx_data};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_d       = out_q;
        bv_d        = 1'b0;
        fe_d        = 1'b0;
        te_d        = 1'b0;
        timer_clear = 1'b0;
        timer_run   = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (rx_valid && rx_err) begin
                    fe_d = 1'b1;
                end else if (rx_valid) begin
                    shreg_d = shifted[PART_W-1:0];
                    cnt_d   = CNT_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_err) begin
                    fe_d        = 1'b1;
                    cnt_d       = '0;
                    timer_clear = 1'b1;
                    state_d     = IDLE;
                end else if (rx_valid) begin
                    timer_clear = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        out_d   = shifted;
                        bv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shreg_d = shifted[PART_W-1:0];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else if (timer_expired) begin
                    te_d        = 1'b1;
                    cnt_d       = '0;
                    timer_clear = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_run = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
            te_q    <= te_d;
        end
    end

    assign uart_rx_bytes = out_q;
    assign bytes_valid   = bv_q;
    assign frame_err     = fe_q;
    assign timeout_err   = te_q;
    assign busy          = (state_q == COLLECT);

endmodule
